// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared encodings, widths and EX/MEM record for the memory stage
package mem_stage_pkg;

  localparam int PC_W  = 5;
  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    JT_NONE   = 2'b00,
    JT_BRANCH = 2'b01,
    JT_JAL    = 2'b10,
    JT_JALR   = 2'b11
  } jump_kind_e;

  typedef enum logic [1:0] {
    BC_EQ = 2'b00,
    BC_NE = 2'b01,
    BC_LT = 2'b10,
    BC_GE = 2'b11
  } branch_cond_e;

  typedef struct packed {
    logic             valid;
    logic [PC_W-1:0]  pc;
    logic [XLEN-1:0]  alu;
    logic [XLEN-1:0]  wdata;
    branch_cond_e     cond;
    jump_kind_e       kind;
    logic             reg_we;
    logic [REG_W-1:0] rd;
    logic             mem_we;
    logic             mem_to_reg;
  } ex_mem_t;

  // blt/bge only look at bit 0: the ALU hands over a set-less-than result
  function automatic logic ctrl_taken(input jump_kind_e kind, input branch_cond_e cond,
                                      input logic [XLEN-1:0] val);
    logic t;
    t = 1'b0;
    case (kind)
      JT_NONE: t = 1'b0;
      JT_BRANCH: begin
        case (cond)
          BC_EQ:   t = (val == '0);
          BC_NE:   t = (val != '0);
          BC_LT:   t = val[0];
          BC_GE:   t = ~val[0];
          default: t = 1'b0;
        endcase
      end
      default: t = 1'b1;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mem_stage_dmem.sv
// rtl/mem_stage_dmem.sv - data memory: combinational read, synchronous write, no reset
module dmem
  import mem_stage_pkg::*;
#(
  parameter int DMEM_WORDS = 32,
  parameter int AW         = $clog2(DMEM_WORDS)
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] wr_data,
  output logic [XLEN-1:0] rd_data
);

  logic [XLEN-1:0] mem_q [DMEM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[addr] <= wr_data;
  end

  assign rd_data = mem_q[addr];

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - EX/MEM + data access + MEM/WB; MEM_FWD_EN adds fwd_valid/fwd_reg/fwd_data
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DMEM_WORDS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [XLEN-1:0]  alu_res,
  input  logic [XLEN-1:0]  write_data,
  input  logic [3:0]       jump_type,
  input  logic             reg_wrenable,
  input  logic [REG_W-1:0] write_reg,
  input  logic             mem_wrenable,
  input  logic             mem_to_reg,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             wb_en,
  output logic [REG_W-1:0] wb_reg,
  output logic [XLEN-1:0]  wb_data
`ifdef MEM_FWD_EN
  ,
  output logic             fwd_valid,
  output logic [REG_W-1:0] fwd_reg,
  output logic [XLEN-1:0]  fwd_data
`endif
);

  localparam int AW = $clog2(DMEM_WORDS);

  ex_mem_t          ex_in, ex_d, ex_q;
  logic             wb_en_d, wb_en_q;
  logic [REG_W-1:0] wb_reg_d, wb_reg_q;
  logic [XLEN-1:0]  wb_data_d, wb_data_q;
  logic [XLEN-1:0]  rd_data;
  logic             mem_wr;

  always_comb begin
    ex_in            = '0;
    ex_in.valid      = in_valid;
    ex_in.pc         = in_pc;
    ex_in.alu        = alu_res;
    ex_in.wdata      = write_data;
    ex_in.cond       = branch_cond_e'(jump_type[3:2]);
    ex_in.kind       = jump_kind_e'(jump_type[1:0]);
    ex_in.reg_we     = reg_wrenable;
    ex_in.rd         = write_reg;
    ex_in.mem_we     = mem_wrenable;
    ex_in.mem_to_reg = mem_to_reg;
  end

  // flush outranks stall so a held instruction can still be squashed
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d       = ex_in;
      ex_d.valid = 1'b0;
    end else if (!stall) begin
      ex_d = ex_in;
    end
  end

  assign mem_wr = ex_q.valid & ex_q.mem_we & ~stall;

  dmem #(.DMEM_WORDS(DMEM_WORDS)) u_dmem (
    .clk     (clk),
    .wr_en   (mem_wr),
    .addr    (ex_q.alu[AW-1:0]),
    .wr_data (ex_q.wdata),
    .rd_data (rd_data)
  );

  always_comb begin
    wb_en_d  = ex_q.valid & ex_q.reg_we & ~stall;
    wb_reg_d = ex_q.rd;
    if (ex_q.mem_to_reg) begin
      wb_data_d = rd_data;
    end else if (ex_q.kind == JT_JAL || ex_q.kind == JT_JALR) begin
      wb_data_d = ex_q.wdata;
    end else begin
      wb_data_d = ex_q.alu;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      wb_en_q   <= 1'b0;
      wb_reg_q  <= '0;
      wb_data_q <= '0;
    end else begin
      ex_q      <= ex_d;
      wb_en_q   <= wb_en_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign redirect_valid = ex_q.valid & ctrl_taken(ex_q.kind, ex_q.cond, ex_q.alu);
  assign redirect_pc    = ex_q.pc;
  assign wb_en          = wb_en_q;
  assign wb_reg         = wb_reg_q;
  assign wb_data        = wb_data_q;

`ifdef MEM_FWD_EN
  assign fwd_valid = ex_q.valid & ex_q.reg_we;
  assign fwd_reg   = ex_q.rd;
  assign fwd_data  = wb_data_d;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with a behavioural model
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [4:0]  in_pc = '0;
  logic [31:0] alu_res = '0, write_data = '0;
  logic [3:0]  jump_type = '0;
  logic        reg_wrenable = 1'b0;
  logic [4:0]  write_reg = '0;
  logic        mem_wrenable = 1'b0, mem_to_reg = 1'b0;
  logic        redirect_valid;
  logic [4:0]  redirect_pc;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
`ifdef MEM_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .in_pc(in_pc), .alu_res(alu_res), .write_data(write_data), .jump_type(jump_type),
    .reg_wrenable(reg_wrenable), .write_reg(write_reg), .mem_wrenable(mem_wrenable),
    .mem_to_reg(mem_to_reg), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data)
`ifdef MEM_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
`endif
  );

  typedef struct {
    bit          v;
    logic [4:0]  pc;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [3:0]  jt;
    bit          rwe;
    logic [4:0]  wr;
    bit          mwe;
    bit          m2r;
  } instr_t;

  instr_t      m_ex;
  bit          m_wb_en = 1'b0;
  logic [4:0]  m_wb_reg = '0;
  logic [31:0] m_wb_data = '0;
  logic [31:0] m_mem [32];

  function automatic bit m_taken(instr_t i);
    if (!i.v) return 1'b0;
    if (i.jt[1:0] == 2'd0) return 1'b0;
    if (i.jt[1]) return 1'b1;
    case (i.jt[3:2])
      2'd0:    return i.alu == 32'd0;
      2'd1:    return i.alu != 32'd0;
      2'd2:    return i.alu[0] == 1'b1;
      default: return i.alu[0] == 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_result(instr_t i);
    if (i.m2r) return m_mem[i.alu[4:0]];
    if (i.jt[1]) return i.wd;
    return i.alu;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex.v    = 1'b0;
      m_wb_en   = 1'b0;
      m_wb_reg  = '0;
      m_wb_data = '0;
    end else begin
      m_wb_en   = m_ex.v && m_ex.rwe && !stall;
      m_wb_reg  = m_ex.wr;
      m_wb_data = m_result(m_ex);
      if (m_ex.v && m_ex.mwe && !stall) m_mem[m_ex.alu[4:0]] = m_ex.wd;
      if (flush) m_ex.v = 1'b0;
      else if (!stall)
        m_ex = '{in_valid, in_pc, alu_res, write_data, jump_type,
                 reg_wrenable, write_reg, mem_wrenable, mem_to_reg};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_redirect_valid", 32'(redirect_valid), 32'(m_taken(m_ex)));
      if (m_taken(m_ex)) chk("m_redirect_pc", 32'(redirect_pc), 32'(m_ex.pc));
      chk("m_wb_en", 32'(wb_en), 32'(m_wb_en));
      if (m_wb_en) begin
        chk("m_wb_reg", 32'(wb_reg), 32'(m_wb_reg));
        chk("m_wb_data", wb_data, m_wb_data);
      end
`ifdef MEM_FWD_EN
      chk("m_fwd_valid", 32'(fwd_valid), 32'(m_ex.v && m_ex.rwe));
      if (m_ex.v && m_ex.rwe) begin
        chk("m_fwd_reg", 32'(fwd_reg), 32'(m_ex.wr));
        chk("m_fwd_data", fwd_data, m_result(m_ex));
      end
`endif
    end
  end

  task automatic idle();
    in_valid = 0; stall = 0; flush = 0; jump_type = 0;
    reg_wrenable = 0; mem_wrenable = 0; mem_to_reg = 0;
  endtask

  task automatic drive(input bit v, input logic [4:0] pc, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] jt, input bit rwe,
                       input logic [4:0] wr, input bit mwe, input bit m2r);
    in_valid = v; in_pc = pc; alu_res = a; write_data = wd; jump_type = jt;
    reg_wrenable = rwe; write_reg = wr; mem_wrenable = mwe; mem_to_reg = m2r;
    stall = 0; flush = 0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [3:0]  br_jt  [4] = '{4'b0001, 4'b0101, 4'b1001, 4'b1101};
  logic [31:0] br_alu [4] = '{32'd0, 32'd0, 32'd1, 32'd1};
  logic        br_exp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    // reset held with a live store on the inputs
    drive(1, 5'd3, 32'd3, 32'h0BAD0BAD, 4'b0000, 1, 5'd2, 1, 0);
    step(3);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst_redirect_pc", 32'(redirect_pc), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_wb_reg", 32'(wb_reg), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    idle();
    rst_n = 1'b1;
    chk_on = 1'b1;

    for (int i = 0; i < 32; i++) begin
      drive(1, 5'd0, 32'(i), 32'hA5A50000 + 32'(i), 4'b0000, 0, 5'd0, 1, 0);
      step(1);
    end
    idle();
    step(2);

    // reset mid-operation drops a captured store to address 3
    drive(1, 5'd0, 32'd3, 32'h0BAD0BAD, 4'b0000, 1, 5'd2, 1, 0);
    step(1);
    #2 rst_n = 1'b0;
    step(1);
    chk("midrst_wb_en", 32'(wb_en), 32'd0);
    chk("midrst_redirect", 32'(redirect_valid), 32'd0);
    drive(1, 5'd0, 32'h77, 32'd0, 4'b0000, 1, 5'd5, 0, 0);
    rst_n = 1'b1;
    step(1);
    idle();
    chk("lat_one_edge_wb_en", 32'(wb_en), 32'd0);
    step(1);
    chk("lat_two_edge_wb_en", 32'(wb_en), 32'd1);
    chk("lat_wb_reg", 32'(wb_reg), 32'd5);
    chk("lat_wb_data", wb_data, 32'h77);
    drive(1, 5'd0, 32'd3, 32'd0, 4'b0000, 1, 5'd6, 0, 1);
    step(1);
    idle();
    step(1);
    chk("rst_no_store", wb_data, 32'hA5A50003);

    // store then load through the wrapped address
    drive(1, 5'd0, 32'd7, 32'hDEADBEEF, 4'b0000, 0, 5'd0, 1, 0);
    step(1);
    drive(1, 5'd0, 32'h27, 32'd0, 4'b0000, 1, 5'd3, 0, 1);
    step(1);
    idle();
    step(1);
    chk("ld_wb_en", 32'(wb_en), 32'd1);
    chk("ld_wb_reg", 32'(wb_reg), 32'd3);
    chk("ld_wb_data", wb_data, 32'hDEADBEEF);

    drive(1, 5'd12, 32'd3, 32'd5, 4'b0010, 1, 5'd1, 0, 0);
    step(1);
    chk("jal_redirect_valid", 32'(redirect_valid), 32'd1);
    chk("jal_redirect_pc", 32'(redirect_pc), 32'd12);
    idle();
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("jal_redirect_drop", 32'(redirect_valid), 32'd0);
    chk("jal_wb_data", wb_data, 32'd5);

    for (int k = 0; k < 4; k++) begin
      drive(1, 5'd20, br_alu[k], 32'd0, br_jt[k], 0, 5'd0, 0, 0);
      step(1);
      chk($sformatf("branch_%0d", k), 32'(redirect_valid), 32'(br_exp[k]));
      idle();
      step(1);
    end

    // store held by two stall cycles commits once at release
    drive(1, 5'd0, 32'd9, 32'h12345678, 4'b0000, 1, 5'd8, 1, 0);
    step(1);
    idle();
    stall = 1'b1;
    step(1);
    chk("stall1_wb_en", 32'(wb_en), 32'd0);
    step(1);
    chk("stall2_wb_en", 32'(wb_en), 32'd0);
    stall = 1'b0;
    step(1);
    chk("release_wb_en", 32'(wb_en), 32'd1);
    drive(1, 5'd0, 32'd9, 32'd0, 4'b0000, 1, 5'd7, 0, 1);
    step(1);
    idle();
    step(1);
    chk("stall_store_data", wb_data, 32'h12345678);

    drive(1, 5'd0, 32'd10, 32'hCAFEF00D, 4'b0000, 0, 5'd0, 1, 0);
    step(1);
    idle();
    stall = 1'b1;
    flush = 1'b1;
    step(1);
    idle();
    step(1);
    drive(1, 5'd0, 32'd10, 32'd0, 4'b0000, 1, 5'd7, 0, 1);
    step(1);
    idle();
    step(1);
    chk("stallflush_no_store", wb_data, 32'hA5A5000A);

`ifdef MEM_FWD_EN
    drive(1, 5'd0, 32'h55, 32'd0, 4'b0000, 1, 5'd4, 0, 0);
    step(1);
    idle();
    chk("fwd_valid", 32'(fwd_valid), 32'd1);
    chk("fwd_reg", 32'(fwd_reg), 32'd4);
    chk("fwd_data", fwd_data, 32'h55);
    step(1);
    chk("fwd_then_wb", wb_data, 32'h55);
`endif

    for (int c = 0; c < 2000; c++) begin
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0:       a = 32'd0;
        1:       a = 32'($urandom_range(0, 3));
        default: a = $urandom;
      endcase
      drive($urandom_range(0, 3) != 0, 5'($urandom), a, $urandom, 4'($urandom),
            1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      step(1);
    end
    idle();
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
